// File: rtl/hazard_ctrl_unit_if.sv
// Bundle between the pipeline control path and hazard_ctrl_unit.
// The pipeline drives through the master modport; the hazard unit uses the slave modport.
interface hazard_ctrl_unit_if #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2
);
   logic                          enable;
   logic                          id_valid;
   logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
   logic [NUM_SRC-1:0]            id_rs_used;
   logic [REG_ADDR_W-1:0]         id_rd;
   logic                          id_reg_write;
   logic                          id_mem_read;
   logic                          ex_branch_taken;
   logic                          mem_busy;

   logic                          stall_if_id;
   logic                          bubble_id_ex;
   logic                          flush_if_id;
   logic                          freeze_all;
   logic [NUM_SRC*2-1:0]          fwd_sel;
   logic [31:0]                   stall_cnt;
   logic [31:0]                   flush_cnt;

   modport master (
      output enable, id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_mem_read,
             ex_branch_taken, mem_busy,
      input  stall_if_id, bubble_id_ex, flush_if_id, freeze_all, fwd_sel,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  enable, id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_mem_read,
             ex_branch_taken, mem_busy,
      output stall_if_id, bubble_id_ex, flush_if_id, freeze_all, fwd_sel,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipe: forwarding selects, load-use stall, branch flush, memory freeze.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
   parameter int REG_ADDR_W       = 5,
   parameter int NUM_SRC          = 2,
   parameter int RF_WRITE_THROUGH = 1
) (
   input  logic               clk,
   input  logic               arst_n,
   hazard_ctrl_unit_if.slave  hz_io
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } tag_t;

   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_EXMEM  = 2'b01;
   localparam logic [1:0] FWD_MEMWB  = 2'b10;
   localparam logic [1:0] FWD_REPLAY = 2'b11;

   // x0 is hardwired zero, so a producer targeting it never creates a dependency
   function automatic logic tag_match(input tag_t p, input logic used,
                                      input logic [REG_ADDR_W-1:0] rs);
      return p.valid & p.reg_write & (p.rd != REG_ADDR_W'(0)) & used & (rs == p.rd);
   endfunction

   tag_t                 ex_q, ex_d;
   tag_t                 mem_q, mem_d;
   tag_t                 wb_q, wb_d;
   logic [NUM_SRC*2-1:0] fwd_q, fwd_d;
   logic [NUM_SRC*2-1:0] fwd_new_s;
   logic [NUM_SRC-1:0]   ex_hit_s, mem_hit_s, wb_hit_s;
   logic                 run_s, load_use_s, flush_s, stall_s, bubble_s;

   // Compare each used source against the three producer tags
   always_comb begin
      ex_hit_s  = '0;
      mem_hit_s = '0;
      wb_hit_s  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ex_hit_s[i]  = tag_match(ex_q,  hz_io.id_rs_used[i], hz_io.id_rs[i*REG_ADDR_W +: REG_ADDR_W]);
         mem_hit_s[i] = tag_match(mem_q, hz_io.id_rs_used[i], hz_io.id_rs[i*REG_ADDR_W +: REG_ADDR_W]);
         wb_hit_s[i]  = tag_match(wb_q,  hz_io.id_rs_used[i], hz_io.id_rs[i*REG_ADDR_W +: REG_ADDR_W]);
      end
   end

   // Per-source forwarding select; the youngest producer wins
   always_comb begin
      fwd_new_s = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ex_hit_s[i]) begin
            fwd_new_s[i*2 +: 2] = FWD_EXMEM;
         end else if (mem_hit_s[i]) begin
            fwd_new_s[i*2 +: 2] = FWD_MEMWB;
         end else if ((RF_WRITE_THROUGH == 0) && wb_hit_s[i]) begin
            fwd_new_s[i*2 +: 2] = FWD_REPLAY;
         end else begin
            fwd_new_s[i*2 +: 2] = FWD_RF;
         end
      end
   end

   // Control decode: mem_busy beats a taken branch, which beats load-use
   always_comb begin
      run_s      = hz_io.enable & ~hz_io.mem_busy;
      load_use_s = hz_io.id_valid & (|ex_hit_s) & ex_q.mem_read;
      flush_s    = run_s & hz_io.ex_branch_taken;
      stall_s    = run_s & ~hz_io.ex_branch_taken & load_use_s;
      bubble_s   = flush_s | stall_s;
   end

   assign hz_io.stall_if_id  = stall_s;
   assign hz_io.bubble_id_ex = bubble_s;
   assign hz_io.flush_if_id  = flush_s;
   assign hz_io.freeze_all   = hz_io.enable & hz_io.mem_busy;
   assign hz_io.fwd_sel      = fwd_q;

   // Tag shadow and forwarding-select next state; everything holds unless the pipe advances
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      fwd_d = fwd_q;
      if (run_s) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         if (bubble_s) begin
            ex_d  = '0;
            fwd_d = '0;
         end else begin
            ex_d.valid     = hz_io.id_valid;
            ex_d.rd        = hz_io.id_rd;
            ex_d.reg_write = hz_io.id_reg_write;
            ex_d.mem_read  = hz_io.id_mem_read;
            fwd_d          = fwd_new_s;
         end
      end else begin
         fwd_d = fwd_q;
      end
   end

   // Tag shadow and forwarding-select registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         fwd_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         fwd_q <= fwd_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Counters wrap naturally at 2^32; stall_s/flush_s already exclude freeze and disable
   always_comb begin
      stall_cnt_d = stall_cnt_q + (stall_s ? 32'd1 : 32'd0);
      flush_cnt_d = flush_cnt_q + (flush_s ? 32'd1 : 32'd0);
   end

   // Perf counter registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz_io.stall_cnt = stall_cnt_q;
   assign hz_io.flush_cnt = flush_cnt_q;
`else
   assign hz_io.stall_cnt = 32'd0;
   assign hz_io.flush_cnt = 32'd0;
`endif

endmodule
